imem_boot_loader: RTL
=====================

// Module: imem_boot_loader
// PURPOSE
//  Byte-stream program loader sitting upstream of the MIPS core's instruction memory.
//  Receives a framed program (count, words, checksum) over a valid/ready byte interface.
//  Writes each assembled word into the i_mem write port and holds the core in reset until a verified load completes.
//  On checksum or length failure, keeps the core in reset and flags an error.
// PARAMETERS
//  ADDR_W     8            log2 of i_mem depth in words; capacity = 2**ADDR_W words
//  BASE_ADDR  32'h0000_0000  byte address of first program word (word aligned)
// PORTS
//  clock        in   1       single clock, all state on rising edge
//  reset        in   1       synchronous, active-high
//  in_valid     in   1       byte available on in_data
//  in_data      in   8       program stream byte
//  in_ready     out  1       loader accepts byte this cycle (transfer = in_valid & in_ready)
//  imem_we      out  1       one-cycle write strobe to i_mem
//  imem_addr    out  32      byte address of write (BASE_ADDR + 4*index), same space as PC
//  imem_wdata   out  32      instruction word to write
//  core_reset   out  1       reset to MIPS core; 1 until load verified
//  done         out  1       sticky: load verified, core released
//  error        out  1       sticky: load rejected
//  words_loaded out  ADDR_W+1  number of data words written so far
// BEHAVIOUR
//  Reset: one clock, synchronous, active-high; polarity and synchronicity are fixed. Reset dominates every other input.
//  Reset values: state=HDR, in_ready=0 during the reset cycle, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0,
//   core_reset=1, done=0, error=0, words_loaded=0, byte counter=0, checksum=0.
//  Framing, all words big-endian (first byte -> [31:24]):
//   word 0 = N (data word count); words 1..N = program; word N+1 = 32-bit sum of data words mod 2**32.
//  Byte assembly: a 2-bit byte counter advances per transfer and wraps 3->0; a word completes on the 4th byte.
//  FSM states: HDR, DATA, CSUM, DONE, ERR.
//   HDR: on word complete, latch N.
//    N > 2**ADDR_W -> ERR.
//    N == 0 -> CSUM.
//    Otherwise -> DATA.
//   DATA: on word complete, the next cycle drives imem_we=1 for exactly one cycle with
//    imem_addr=BASE_ADDR+4*idx and imem_wdata=word; idx, words_loaded and checksum update in that same cycle.
//    After the Nth word -> CSUM.
//   CSUM: on word complete, compare against the running sum.
//    Equal -> DONE.
//    Not equal -> ERR.
//   DONE: in_ready=0, done=1, core_reset=0 from the cycle after the CSUM word's last byte. Terminal until reset.
//   ERR: in_ready=0, error=1, core_reset=1. Terminal until reset.
//  in_ready is 1 in HDR/DATA/CSUM (after reset deasserts), including the cycle imem_we is pulsed, so a
//   back-to-back stream of one byte per cycle is accepted with no stalls.
//  in_valid gaps: byte counter and partial word hold; no timeout.
//  Reset mid-load: partial word discarded, FSM returns to HDR, core_reset=1.
//   Words already written to i_mem stay in i_mem; they are not cleared.
//  imem_addr arithmetic wraps modulo 2**32 (unreachable given the N check).
//  done and error are never 1 simultaneously.
// TESTING
//  1 N=3, words 20080005,20090003,01095020, csum 411A5028, 1 byte/clk -> three imem_we pulses at addr 0,4,8;
//    done=1 and core_reset=0 one clock after the last byte; words_loaded=3.
//  2 Same stream with csum 411A5029 -> error=1, done=0, core_reset stays 1, in_ready=0 afterwards.
//  3 N=0, csum 00000000 -> no imem_we; done=1.
//  4 N=0x101 with ADDR_W=8 -> error=1 after the 4th header byte; no imem_we.
//  5 Case 1 with random 0-5 cycle in_valid gaps -> identical writes and addresses; no byte lost or duplicated.
//  6 Reset asserted after 2 data words plus 2 bytes, then full case-1 stream -> words_loaded restarts at 0;
//    writes at 0,4,8; done=1.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Byte-stream program loader for the MIPS instruction memory.
// Assembles framed big-endian words, writes i_mem, releases core on a good checksum.
module imem_boot_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [31:0]       imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        HDR,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [32:0] CAP = 33'(1) << ADDR_W;

    state_t          state;
    logic [1:0]      byte_cnt;
    logic [23:0]     partial;
    logic [ADDR_W:0] n_words;
    logic [31:0]     csum;
    logic            rdy_q;

    logic            xfer;
    logic            word_done;
    logic [31:0]     word;
    logic [31:0]     next_addr;
    logic [ADDR_W:0] loaded_inc;

    // Reset gates in_ready combinationally so no byte is taken in the reset cycle.
    assign in_ready   = rdy_q && !reset;
    assign xfer       = in_valid && in_ready;
    assign word_done  = xfer && (byte_cnt == 2'd3);
    assign word       = {partial, in_data};
    assign next_addr  = BASE_ADDR + (32'(words_loaded) << 2);
    assign loaded_inc = words_loaded + (ADDR_W+1)'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= HDR;
            rdy_q        <= 1'b1;
            imem_we      <= 1'b0;
            imem_addr    <= BASE_ADDR;
            imem_wdata   <= 32'h0;
            core_reset   <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            n_words      <= '0;
            byte_cnt     <= 2'd0;
            partial      <= 24'h0;
            csum         <= 32'h0;
        end else begin
            imem_we <= 1'b0;
            if (xfer) begin
                byte_cnt <= byte_cnt + 2'd1;
                partial  <= {partial[15:0], in_data};
            end
            if (word_done) begin
                unique case (state)
                    HDR: begin
                        if ({1'b0, word} > CAP) begin
                            state <= ERR;
                            rdy_q <= 1'b0;
                            error <= 1'b1;
                        end else begin
                            n_words <= word[ADDR_W:0];
                            state   <= (word == 32'h0) ? CSUM : DATA;
                        end
                    end
                    DATA: begin
                        imem_we      <= 1'b1;
                        imem_addr    <= next_addr;
                        imem_wdata   <= word;
                        words_loaded <= loaded_inc;
                        csum         <= csum + word;
                        if (loaded_inc == n_words) begin
                            state <= CSUM;
                        end
                    end
                    CSUM: begin
                        rdy_q <= 1'b0;
                        if (word == csum) begin
                            state      <= DONE;
                            done       <= 1'b1;
                            core_reset <= 1'b0;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                    DONE: begin
                    end
                    ERR: begin
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
